// File: rtl/paging_unit_tlb_if.sv
// Request, result and page-walk read-bus signals of the paging unit.
interface paging_unit_tlb_if;
    localparam int unsigned AW = 32;
    localparam int unsigned EW = 3;

    logic          i_valid;
    logic          o_ready;
    logic [AW-1:0] i_linear_address;
    logic          i_write;
    logic          i_user;
    logic [AW-1:0] i_page_directory_base;
    logic          i_paging_enable;
    logic          i_tlb_flush;
    logic [AW-1:0] o_physical_address;
    logic          o_page_fault;
    logic [AW-1:0] o_fault_linear_address;
    logic [EW-1:0] o_fault_error_code;
    logic          o_bus_valid;
    logic          i_bus_ready;
    logic [AW-1:0] o_bus_address;
    logic [AW-1:0] i_bus_data_read;
    logic          o_bus_write_enable;

    modport master (
        output i_valid, i_linear_address, i_write, i_user, i_page_directory_base,
               i_paging_enable, i_tlb_flush, i_bus_ready, i_bus_data_read,
        input  o_ready, o_physical_address, o_page_fault, o_fault_linear_address,
               o_fault_error_code, o_bus_valid, o_bus_address, o_bus_write_enable
    );

    modport slave (
        input  i_valid, i_linear_address, i_write, i_user, i_page_directory_base,
               i_paging_enable, i_tlb_flush, i_bus_ready, i_bus_data_read,
        output o_ready, o_physical_address, o_page_fault, o_fault_linear_address,
               o_fault_error_code, o_bus_valid, o_bus_address, o_bus_write_enable
    );
endinterface

// File: rtl/paging_unit_tlb.sv
// Two-level x86-style paging unit with a fully associative TLB.
// Misses walk PDE then PTE over a valid/ready read bus; successful walks are cached.
module paging_unit_tlb #(
    parameter int unsigned TLB_ENTRIES = 8,
    parameter int unsigned BUS_WIDTH   = 32
) (
    input logic              clock,
    input logic              reset,
    paging_unit_tlb_if.slave bus
);
    localparam int unsigned AW = BUS_WIDTH;
    localparam int unsigned TW = AW - 12;
    localparam int unsigned IW = $clog2(TLB_ENTRIES);

    typedef enum logic [1:0] {S_IDLE, S_PDE_REQ, S_PTE_REQ} state_e;

    state_e state_q, state_d;

    logic [AW-1:0]          lin_q, lin_d;
    logic                   write_q, write_d;
    logic                   user_q, user_d;
    logic                   pde_u_q, pde_u_d;
    logic                   pde_w_q, pde_w_d;
    logic                   flush_seen_q, flush_seen_d;
    logic                   ready_q, ready_d;
    logic                   fault_q, fault_d;
    logic [AW-1:0]          phys_q, phys_d;
    logic [AW-1:0]          cr2_q, cr2_d;
    logic [2:0]             code_q, code_d;
    logic                   bus_valid_q, bus_valid_d;
    logic [AW-1:0]          bus_addr_q, bus_addr_d;
    logic [TLB_ENTRIES-1:0] valid_q, valid_d;
    logic [TLB_ENTRIES-1:0] u_q, u_d;
    logic [TLB_ENTRIES-1:0] w_q, w_d;
    logic [TW-1:0]          tag_q   [TLB_ENTRIES];
    logic [TW-1:0]          tag_d   [TLB_ENTRIES];
    logic [TW-1:0]          frame_q [TLB_ENTRIES];
    logic [TW-1:0]          frame_d [TLB_ENTRIES];
    logic [IW-1:0]          rr_q, rr_d;

    logic          hit;
    logic [IW-1:0] hit_idx;
    logic          free_found;
    logic [IW-1:0] free_idx;
    logic          install;
    logic [IW-1:0] inst_idx;
    logic [AW-1:0] rd;
    logic          walk_u;
    logic          walk_w;
    logic          unused_bits;

    assign unused_bits = ^{bus.i_page_directory_base[11:0], bus.i_bus_data_read[11:3]};

    function automatic logic perm_fault(input logic user, input logic write,
                                        input logic u, input logic w);
        return user & (~u | (write & ~w));
    endfunction

    // A flush in the lookup cycle forces a miss.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < int'(TLB_ENTRIES); i++) begin
            if (!hit && valid_q[i] && (tag_q[i] == bus.i_linear_address[AW-1:12])) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
        if (bus.i_tlb_flush) hit = 1'b0;
    end

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < int'(TLB_ENTRIES); i++) begin
            if (!free_found && !valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (bus.i_valid && bus.i_paging_enable && !hit) state_d = S_PDE_REQ;
            S_PDE_REQ: if (bus.i_bus_ready) state_d = bus.i_bus_data_read[0] ? S_PTE_REQ : S_IDLE;
            S_PTE_REQ: if (bus.i_bus_ready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        lin_d        = lin_q;
        write_d      = write_q;
        user_d       = user_q;
        pde_u_d      = pde_u_q;
        pde_w_d      = pde_w_q;
        flush_seen_d = flush_seen_q;
        ready_d      = 1'b0;
        fault_d      = 1'b0;
        phys_d       = phys_q;
        cr2_d        = cr2_q;
        code_d       = code_q;
        bus_valid_d  = bus_valid_q;
        bus_addr_d   = bus_addr_q;
        valid_d      = valid_q;
        u_d          = u_q;
        w_d          = w_q;
        tag_d        = tag_q;
        frame_d      = frame_q;
        rr_d         = rr_q;
        install      = 1'b0;
        inst_idx     = free_found ? free_idx : rr_q;
        rd           = bus.i_bus_data_read;
        walk_u       = pde_u_q & rd[2];
        walk_w       = pde_w_q & rd[1];

        case (state_q)
            S_IDLE: begin
                if (bus.i_valid) begin
                    lin_d        = bus.i_linear_address;
                    write_d      = bus.i_write;
                    user_d       = bus.i_user;
                    flush_seen_d = 1'b0;
                    if (!bus.i_paging_enable) begin
                        ready_d = 1'b1;
                        phys_d  = bus.i_linear_address;
                    end else if (hit) begin
                        ready_d = 1'b1;
                        if (perm_fault(bus.i_user, bus.i_write, u_q[hit_idx], w_q[hit_idx])) begin
                            fault_d = 1'b1;
                            cr2_d   = bus.i_linear_address;
                            code_d  = {bus.i_user, bus.i_write, 1'b1};
                        end else begin
                            phys_d = {frame_q[hit_idx], bus.i_linear_address[11:0]};
                        end
                    end else begin
                        bus_valid_d = 1'b1;
                        bus_addr_d  = {bus.i_page_directory_base[AW-1:12],
                                       bus.i_linear_address[AW-1:22], 2'b00};
                    end
                end
            end
            S_PDE_REQ: begin
                flush_seen_d = flush_seen_q | bus.i_tlb_flush;
                if (bus.i_bus_ready) begin
                    pde_u_d = rd[2];
                    pde_w_d = rd[1];
                    if (!rd[0]) begin
                        bus_valid_d = 1'b0;
                        ready_d     = 1'b1;
                        fault_d     = 1'b1;
                        cr2_d       = lin_q;
                        code_d      = {user_q, write_q, 1'b0};
                    end else begin
                        bus_addr_d = {rd[AW-1:12], lin_q[21:12], 2'b00};
                    end
                end
            end
            S_PTE_REQ: begin
                flush_seen_d = flush_seen_q | bus.i_tlb_flush;
                if (bus.i_bus_ready) begin
                    bus_valid_d = 1'b0;
                    ready_d     = 1'b1;
                    if (!rd[0] || perm_fault(user_q, write_q, walk_u, walk_w)) begin
                        fault_d = 1'b1;
                        cr2_d   = lin_q;
                        code_d  = {user_q, write_q, rd[0]};
                    end else begin
                        phys_d  = {rd[AW-1:12], lin_q[11:0]};
                        install = ~(flush_seen_q | bus.i_tlb_flush);
                    end
                end
            end
            default: ;
        endcase

        // Prefer a free slot; only evictions advance the round-robin pointer.
        if (install) begin
            valid_d[inst_idx] = 1'b1;
            tag_d[inst_idx]   = lin_q[AW-1:12];
            frame_d[inst_idx] = rd[AW-1:12];
            u_d[inst_idx]     = walk_u;
            w_d[inst_idx]     = walk_w;
            if (!free_found) rr_d = rr_q + IW'(1);
        end
        if (bus.i_tlb_flush) valid_d = '0;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            lin_q        <= '0;
            write_q      <= 1'b0;
            user_q       <= 1'b0;
            pde_u_q      <= 1'b0;
            pde_w_q      <= 1'b0;
            flush_seen_q <= 1'b0;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
            phys_q       <= '0;
            cr2_q        <= '0;
            code_q       <= '0;
            bus_valid_q  <= 1'b0;
            bus_addr_q   <= '0;
            valid_q      <= '0;
            u_q          <= '0;
            w_q          <= '0;
            tag_q        <= '{default: '0};
            frame_q      <= '{default: '0};
            rr_q         <= '0;
        end else begin
            lin_q        <= lin_d;
            write_q      <= write_d;
            user_q       <= user_d;
            pde_u_q      <= pde_u_d;
            pde_w_q      <= pde_w_d;
            flush_seen_q <= flush_seen_d;
            ready_q      <= ready_d;
            fault_q      <= fault_d;
            phys_q       <= phys_d;
            cr2_q        <= cr2_d;
            code_q       <= code_d;
            bus_valid_q  <= bus_valid_d;
            bus_addr_q   <= bus_addr_d;
            valid_q      <= valid_d;
            u_q          <= u_d;
            w_q          <= w_d;
            tag_q        <= tag_d;
            frame_q      <= frame_d;
            rr_q         <= rr_d;
        end
    end

    assign bus.o_ready                = ready_q;
    assign bus.o_page_fault           = fault_q;
    assign bus.o_physical_address     = phys_q;
    assign bus.o_fault_linear_address = cr2_q;
    assign bus.o_fault_error_code     = code_q;
    assign bus.o_bus_valid            = bus_valid_q;
    assign bus.o_bus_address          = bus_addr_q;
    assign bus.o_bus_write_enable     = 1'b0;
endmodule

// File: tb/tb_paging_unit_tlb.sv
// Scoreboard bench for paging_unit_tlb: a stalling memory responder checks walk reads,
// a result monitor checks every o_ready pulse against queued expectations.
module tb_paging_unit_tlb;
    typedef struct {
        logic [31:0] phys;
        logic        fault;
        logic [31:0] cr2;
        logic [2:0]  code;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   stall = 0;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] last_phys = 32'h0;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_bus [$];
    exp_t        exp_res [$];

    paging_unit_tlb_if ifc();

    paging_unit_tlb #(.TLB_ENTRIES(2), .BUS_WIDTH(32)) dut (
        .clock (clk),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    // Memory responder: waits `stall` cycles per read, then returns mem[address].
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        ifc.i_bus_ready     = 1'b0;
        ifc.i_bus_data_read = 32'h0;
        forever begin
            @(negedge clk);
            if (ifc.i_bus_ready) begin
                ifc.i_bus_ready = 1'b0;
                wait_cnt = 0;
            end else if (ifc.o_bus_valid) begin
                if (exp_bus.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL bus_unexpected actual_addr=%h required=no_read", ifc.o_bus_address);
                end
                if (wait_cnt >= stall) begin
                    if (exp_bus.size() != 0) chk("bus_addr", ifc.o_bus_address, exp_bus.pop_front());
                    chk("bus_we", 32'(ifc.o_bus_write_enable), 32'h0);
                    ifc.i_bus_data_read = mem.exists(ifc.o_bus_address) ? mem[ifc.o_bus_address] : 32'h0;
                    ifc.i_bus_ready = 1'b1;
                end else begin
                    if (exp_bus.size() != 0) chk("bus_stall_addr", ifc.o_bus_address, exp_bus[0]);
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Result monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ifc.o_ready) begin
                if (exp_res.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL ready_unexpected actual=1 required=0 phys=%h", ifc.o_physical_address);
                end else begin
                    e = exp_res.pop_front();
                    chk("phys", ifc.o_physical_address, e.phys);
                    chk("fault", 32'(ifc.o_page_fault), 32'(e.fault));
                    if (e.fault) begin
                        chk("cr2", ifc.o_fault_linear_address, e.cr2);
                        chk("err_code", 32'(ifc.o_fault_error_code), 32'(e.code));
                    end
                    if (e.lat != 0) chk("latency", 32'(cyc - acc_cyc), 32'(e.lat));
                end
            end
        end
    end

    task automatic push_ok(input logic [31:0] pa, input int lat);
        exp_t e;
        e.phys = pa; e.fault = 1'b0; e.cr2 = 32'h0; e.code = 3'b000; e.lat = lat;
        exp_res.push_back(e);
        last_phys = pa;
    endtask

    task automatic push_fault(input logic [31:0] la, input logic [2:0] code, input int lat);
        exp_t e;
        e.phys = last_phys; e.fault = 1'b1; e.cr2 = la; e.code = code; e.lat = lat;
        exp_res.push_back(e);
    endtask

    task automatic start_req(input logic [31:0] la, input logic w, input logic u, input logic fl);
        @(negedge clk);
        ifc.i_valid          = 1'b1;
        ifc.i_linear_address = la;
        ifc.i_write          = w;
        ifc.i_user           = u;
        ifc.i_tlb_flush      = fl;
        acc_cyc              = cyc;
        @(negedge clk);
        ifc.i_valid     = 1'b0;
        ifc.i_tlb_flush = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_res.size() != 0 || exp_bus.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_res.size() != 0 || exp_bus.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL timeout pending_results=%0d pending_reads=%0d required=0", exp_res.size(), exp_bus.size());
            exp_res.delete();
            exp_bus.delete();
        end
    endtask

    task automatic req(input logic [31:0] la, input logic w, input logic u);
        start_req(la, w, u, 1'b0);
        wait_done();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset                     = 1'b0;
        ifc.i_valid               = 1'b0;
        ifc.i_linear_address      = 32'h0;
        ifc.i_write               = 1'b0;
        ifc.i_user                = 1'b0;
        ifc.i_page_directory_base = 32'h0000_1ABC;
        ifc.i_paging_enable       = 1'b1;
        ifc.i_tlb_flush           = 1'b0;

        mem[32'h0000_1004] = 32'h0000_2007;
        mem[32'h0000_200C] = 32'h0012_3007;
        mem[32'h0000_1008] = 32'h0000_2006;
        mem[32'h0000_100C] = 32'h0000_3007;
        mem[32'h0000_3014] = 32'h0012_3005;
        mem[32'h0000_2010] = 32'h0045_6007;

        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ifc.o_ready), 32'h0);
        chk("rst_fault", 32'(ifc.o_page_fault), 32'h0);
        chk("rst_bus_valid", 32'(ifc.o_bus_valid), 32'h0);
        chk("rst_bus_addr", ifc.o_bus_address, 32'h0);
        chk("rst_phys", ifc.o_physical_address, 32'h0);
        chk("rst_cr2", ifc.o_fault_linear_address, 32'h0);
        chk("rst_code", 32'(ifc.o_fault_error_code), 32'h0);
        reset = 1'b1;

        // Paging disabled: identity mapping, no bus traffic.
        ifc.i_paging_enable = 1'b0;
        push_ok(32'hDEAD_BEEF, 1);
        req(32'hDEAD_BEEF, 1'b1, 1'b1);
        ifc.i_paging_enable = 1'b1;

        // Miss walk with a 5-cycle stall on each read.
        stall = 5;
        exp_bus.push_back(32'h0000_1004);
        exp_bus.push_back(32'h0000_200C);
        push_ok(32'h0012_3ABC, 0);
        req(32'h0040_3ABC, 1'b0, 1'b0);
        stall = 0;

        // Hits on the installed page.
        push_ok(32'h0012_3FFF, 1);
        req(32'h0040_3FFF, 1'b0, 1'b0);
        push_ok(32'h0012_3010, 1);
        req(32'h0040_3010, 1'b1, 1'b1);

        // Not-present PDE: single read, fault, nothing cached.
        exp_bus.push_back(32'h0000_1008);
        push_fault(32'h0080_0123, 3'b010, 0);
        req(32'h0080_0123, 1'b1, 1'b0);
        exp_bus.push_back(32'h0000_1008);
        push_fault(32'h0080_0123, 3'b010, 0);
        req(32'h0080_0123, 1'b1, 1'b0);

        // User write to a read-only page faults and is not cached; a user read then installs it.
        exp_bus.push_back(32'h0000_100C);
        exp_bus.push_back(32'h0000_3014);
        push_fault(32'h00C0_5444, 3'b111, 0);
        req(32'h00C0_5444, 1'b1, 1'b1);
        exp_bus.push_back(32'h0000_100C);
        exp_bus.push_back(32'h0000_3014);
        push_ok(32'h0012_3444, 0);
        req(32'h00C0_5444, 1'b0, 1'b1);
        push_fault(32'h00C0_5000, 3'b111, 1);
        req(32'h00C0_5000, 1'b1, 1'b1);
        push_ok(32'h0012_3008, 1);
        req(32'h00C0_5008, 1'b1, 1'b0);

        // Third page evicts entry 0; entry 1 survives until the next eviction.
        exp_bus.push_back(32'h0000_1004);
        exp_bus.push_back(32'h0000_2010);
        push_ok(32'h0045_6ABC, 0);
        req(32'h0040_4ABC, 1'b0, 1'b0);
        push_ok(32'h0012_3008, 1);
        req(32'h00C0_5008, 1'b0, 1'b0);
        push_ok(32'h0045_6000, 1);
        req(32'h0040_4000, 1'b0, 1'b0);
        exp_bus.push_back(32'h0000_1004);
        exp_bus.push_back(32'h0000_200C);
        push_ok(32'h0012_3000, 0);
        req(32'h0040_3000, 1'b0, 1'b0);

        // Idle flush, then the cached page needs a full walk.
        @(negedge clk);
        ifc.i_tlb_flush = 1'b1;
        @(negedge clk);
        ifc.i_tlb_flush = 1'b0;
        exp_bus.push_back(32'h0000_1004);
        exp_bus.push_back(32'h0000_200C);
        push_ok(32'h0012_3000, 0);
        req(32'h0040_3000, 1'b0, 1'b0);

        // Flush in the lookup cycle forces a miss.
        exp_bus.push_back(32'h0000_1004);
        exp_bus.push_back(32'h0000_200C);
        push_ok(32'h0012_3004, 0);
        start_req(32'h0040_3004, 1'b0, 1'b0, 1'b1);
        wait_done();

        // Flush during a walk: result returned but not cached.
        stall = 5;
        exp_bus.push_back(32'h0000_1004);
        exp_bus.push_back(32'h0000_2010);
        push_ok(32'h0045_6000, 0);
        start_req(32'h0040_4000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        ifc.i_tlb_flush = 1'b1;
        @(negedge clk);
        ifc.i_tlb_flush = 1'b0;
        wait_done();
        stall = 0;
        exp_bus.push_back(32'h0000_1004);
        exp_bus.push_back(32'h0000_2010);
        push_ok(32'h0045_6004, 0);
        req(32'h0040_4004, 1'b0, 1'b0);

        // Reset in the middle of a stalled walk: no result, bus released.
        stall = 100;
        exp_bus.push_back(32'h0000_1004);
        start_req(32'h0040_3ABC, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_ready", 32'(ifc.o_ready), 32'h0);
        chk("midrst_bus_valid", 32'(ifc.o_bus_valid), 32'h0);
        chk("midrst_phys", ifc.o_physical_address, 32'h0);
        reset = 1'b1;
        exp_bus.delete();
        stall = 0;
        last_phys = 32'h0;
        repeat (5) @(negedge clk);

        // Reset also emptied the TLB.
        exp_bus.push_back(32'h0000_1004);
        exp_bus.push_back(32'h0000_2010);
        push_ok(32'h0045_6ABC, 0);
        req(32'h0040_4ABC, 1'b0, 1'b0);
        push_ok(32'h0045_6123, 1);
        req(32'h0040_4123, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
